alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_exec.sv | 33 +++
 rtl/alu_arbiter.sv | 112 +++++++++++
 tb/tb_alu_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the two-requester ALU arbiter.
// Op codes, FSM states and the default datapath width.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_XOR  = 3'b010,
    OP_NOR  = 3'b011,
    OP_ADD  = 3'b100,
    OP_SUB  = 3'b101,
    OP_SLT  = 3'b110,
    OP_PASS = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } arb_state_e;

endpackage

// File: rtl/alu_exec.sv
// Combinational ALU: logic ops, modular add/sub, signed SLT, pass b.
// Shared by both requesters through the arbiter.
module alu_exec
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  alu_op_e          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  logic lt;

  assign lt = $signed(a) < $signed(b);

  always_comb begin
    y = '0;
    unique case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NOR:  y = ~(a | b);
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_SLT:  y = {{(WIDTH-1){1'b0}}, lt};
      OP_PASS: y = b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for one shared ALU.
// Define ALU_ARB_GRANT_CNT_EN to add a saturating grant_cnt output.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_y
`ifdef ALU_ARB_GRANT_CNT_EN
  ,
  output logic [15:0]      grant_cnt
`endif
);

  arb_state_e       state;
  arb_state_e       state_nxt;
  logic             lp;
  logic             grant;
  logic             accept;
  alu_op_e          op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             id_q;
  logic [WIDTH-1:0] y;

  // On a tie the requester that did not win last time goes next.
  assign grant = (req0_valid && req1_valid) ? ~lp : req1_valid;

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    state_nxt  = state;
    unique case (state)
      IDLE: begin
        if (!rst) begin
          req0_ready = req0_valid && !grant;
          req1_ready = req1_valid && grant;
        end
        if (req0_ready || req1_ready) state_nxt = EXEC;
      end
      EXEC: state_nxt = HOLD;
      HOLD: if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign accept = req0_ready || req1_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      lp        <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_y     <= '0;
      rsp_id    <= 1'b0;
      op_q      <= OP_AND;
      a_q       <= '0;
      b_q       <= '0;
      id_q      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q <= alu_op_e'(grant ? req1_op : req0_op);
        a_q  <= grant ? req1_a : req0_a;
        b_q  <= grant ? req1_b : req0_b;
        id_q <= grant;
        lp   <= grant;
      end
      if (state == EXEC) begin
        rsp_valid <= 1'b1;
        rsp_y     <= y;
        rsp_id    <= id_q;
      end
      if (state == HOLD && rsp_ready) rsp_valid <= 1'b0;
    end
  end

  alu_exec #(.WIDTH(WIDTH)) u_exec (
    .op (op_q),
    .a  (a_q),
    .b  (b_q),
    .y  (y)
  );

`ifdef ALU_ARB_GRANT_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt <= '0;
    end else if (accept && grant_cnt != 16'hFFFF) begin
      grant_cnt <= grant_cnt + 16'd1;
    end
  end
`else
  // No accept counter in this build.
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: spec-level model checked every cycle,
// plus directed vectors with hand-computed results.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0;
  logic        req0_ready;
  logic [2:0]  req0_op = 3'd0;
  logic [31:0] req0_a = '0;
  logic [31:0] req0_b = '0;
  logic        req1_valid = 1'b0;
  logic        req1_ready;
  logic [2:0]  req1_op = 3'd0;
  logic [31:0] req1_a = '0;
  logic [31:0] req1_b = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic        rsp_id;
  logic [31:0] rsp_y;
`ifdef ALU_ARB_GRANT_CNT_EN
  logic [15:0] grant_cnt;
`endif

  int vecs = 0;
  int errs = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_y      (rsp_y)
`ifdef ALU_ARB_GRANT_CNT_EN
    ,
    .grant_cnt  (grant_cnt)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] alu_ref(input logic [2:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a ^ b;
      3'd3: return ~(a | b);
      3'd4: return a + b;
      3'd5: return a - b;
      3'd6: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      default: return b;
    endcase
  endfunction

  // Model: busy from acceptance until the response is taken.
  bit          m_busy = 1'b0;
  int          m_age = 0;
  bit          m_lp = 1'b1;
  bit          m_id = 1'b0;
  logic [31:0] m_res = '0;
  bit          m_rv = 1'b0;
  logic [31:0] m_y = '0;
  bit          m_yid = 1'b0;
  logic [15:0] m_cnt = '0;

  always @(posedge clk) begin
    bit g;
    if (rst) begin
      m_busy = 1'b0;
      m_rv   = 1'b0;
      m_y    = '0;
      m_yid  = 1'b0;
      m_lp   = 1'b1;
      m_cnt  = '0;
    end else if (!m_busy) begin
      if (req0_valid || req1_valid) begin
        g      = (req0_valid && req1_valid) ? !m_lp : req1_valid;
        m_res  = g ? alu_ref(req1_op, req1_a, req1_b)
                   : alu_ref(req0_op, req0_a, req0_b);
        m_id   = g;
        m_lp   = g;
        m_busy = 1'b1;
        m_age  = 0;
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end
    end else if (m_age == 0) begin
      m_age = 1;
      m_rv  = 1'b1;
      m_y   = m_res;
      m_yid = m_id;
    end else if (rsp_ready) begin
      m_rv   = 1'b0;
      m_busy = 1'b0;
    end
  end

  always @(negedge clk) begin
    bit e0, e1;
    if (chk_en) begin
      e0 = !rst && !m_busy && req0_valid && (!req1_valid || m_lp);
      e1 = !rst && !m_busy && req1_valid && (!req0_valid || !m_lp);
      chk("mdl_ready0", {31'd0, req0_ready}, {31'd0, e0});
      chk("mdl_ready1", {31'd0, req1_ready}, {31'd0, e1});
      chk("mdl_rsp_valid", {31'd0, rsp_valid}, {31'd0, m_rv});
      chk("mdl_rsp_y", rsp_y, m_y);
      chk("mdl_rsp_id", {31'd0, rsp_id}, {31'd0, m_yid});
`ifdef ALU_ARB_GRANT_CNT_EN
      chk("mdl_grant_cnt", {16'd0, grant_cnt}, {16'd0, m_cnt});
`endif
    end
  end

  task automatic drive_at_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive_at_edge();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic do_op(input bit id, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input string nm);
    bit ok;
    int n;
    drive_at_edge();
    if (id) begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    end else begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    end
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (id ? req1_ready : req0_ready) begin
        ok = 1'b1;
        break;
      end
    end
    drive_at_edge();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    // Operands changing after acceptance must not reach the result.
    req0_a = $urandom; req0_b = $urandom;
    req1_a = $urandom; req1_b = $urandom;
    if (!ok) begin
      chk({nm, "_accept_timeout"}, 32'd0, 32'd1);
      return;
    end
    ok = 1'b0;
    n  = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n++;
      if (rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      chk({nm, "_rsp_timeout"}, 32'd0, 32'd1);
      return;
    end
    chk({nm, "_latency"}, n, 32'd2);
    chk({nm, "_y"}, rsp_y, exp);
    chk({nm, "_id"}, {31'd0, rsp_id}, {31'd0, id});
    drive_at_edge();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int grants[$];
    logic [31:0] y_hold;
    bit id_hold;
    bit ok;

    // Reset state, ready held low while rst is high.
    req0_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    chk("rst_ready0", {31'd0, req0_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_y", rsp_y, 32'd0);
    chk("rst_rsp_id", {31'd0, rsp_id}, 32'd0);
    req0_valid = 1'b0;
    drive_at_edge();
    rst = 1'b0;

`ifdef ALU_ARB_GRANT_CNT_EN
    do_op(1'b0, 3'd4, 32'd1, 32'd2, 32'd3, "cnt_a");
    do_op(1'b1, 3'd4, 32'd3, 32'd4, 32'd7, "cnt_b");
    do_op(1'b0, 3'd4, 32'd5, 32'd6, 32'd11, "cnt_c");
    @(negedge clk);
    chk("cnt_three", {16'd0, grant_cnt}, 32'd3);
    @(posedge clk);
    #2;
    force dut.grant_cnt = 16'hFFFE;
    m_cnt = 16'hFFFE;
    #1;
    release dut.grant_cnt;
    do_op(1'b0, 3'd7, 32'd0, 32'd9, 32'd9, "cnt_d");
    do_op(1'b1, 3'd7, 32'd0, 32'd8, 32'd8, "cnt_e");
    @(negedge clk);
    chk("cnt_sat", {16'd0, grant_cnt}, 32'h0000_FFFF);
`endif

    // Single op and arithmetic edges.
    do_op(1'b0, 3'd1, 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F, "or");
    do_op(1'b0, 3'd4, 32'hFFFF_FFFF, 32'd1, 32'd0, "add_wrap");
    do_op(1'b1, 3'd5, 32'd0, 32'd1, 32'hFFFF_FFFF, "sub_wrap");
    do_op(1'b1, 3'd6, 32'h8000_0000, 32'd1, 32'd1, "slt_neg");
    do_op(1'b0, 3'd6, 32'd1, 32'h8000_0000, 32'd0, "slt_pos");
    do_op(1'b1, 3'd3, 32'd0, 32'd0, 32'hFFFF_FFFF, "nor");
    do_op(1'b0, 3'd2, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, "xor");
    do_op(1'b1, 3'd0, 32'h1234_5678, 32'h0F0F_0F0F, 32'h0204_0608, "and");

    // Tie alternation from reset.
    do_reset();
    req0_valid = 1'b1; req0_op = 3'd4; req0_a = 32'd10; req0_b = 32'd1;
    req1_valid = 1'b1; req1_op = 3'd5; req1_a = 32'd10; req1_b = 32'd1;
    for (int i = 0; i < 40 && grants.size() < 4; i++) begin
      @(negedge clk);
      if (req0_ready) grants.push_back(0);
      if (req1_ready) grants.push_back(1);
    end
    drive_at_edge();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("tie_count", grants.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("tie_grant%0d", i),
          (i < grants.size()) ? grants[i] : 32'hDEAD, i % 2);
    end
    repeat (4) @(posedge clk);

    // Backpressure: response held while rsp_ready is low.
    rsp_ready = 1'b0;
    drive_at_edge();
    req0_valid = 1'b1; req0_op = 3'd4;
    req0_a = 32'd100; req0_b = 32'd23;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req0_ready) begin
        ok = 1'b1;
        break;
      end
    end
    drive_at_edge();
    req0_op = 3'd7; req0_b = 32'd55;
    if (!ok) chk("bp_accept_timeout", 32'd0, 32'd1);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("bp_rsp_timeout", 32'd0, 32'd1);
    y_hold  = rsp_y;
    id_hold = rsp_id;
    chk("bp_y", y_hold, 32'd123);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("bp_y_stable", rsp_y, y_hold);
      chk("bp_id_stable", {31'd0, rsp_id}, {31'd0, id_hold});
      chk("bp_ready0_low", {31'd0, req0_ready}, 32'd0);
      chk("bp_ready1_low", {31'd0, req1_ready}, 32'd0);
    end
    drive_at_edge();
    rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_released", {31'd0, rsp_valid}, 32'd0);
    chk("bp_idle_ready0", {31'd0, req0_ready}, 32'd1);
    drive_at_edge();
    req0_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("bp_second_y", rsp_y, 32'd55);
    repeat (2) @(posedge clk);

    // Reset while an operation is in EXEC.
    drive_at_edge();
    req1_valid = 1'b1; req1_op = 3'd1;
    req1_a = 32'h0000_00F0; req1_b = 32'h0000_000F;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req1_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("rx_accept_timeout", 32'd0, 32'd1);
    drive_at_edge();
    req1_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rx_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rx_rsp_y", rsp_y, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rx_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
